// File: rtl/cache_axi_bridge_if.sv
// Bundles the cache request/return signals and the AXI4 master channels of one bridge.
// The master modport is the bridge's view, the slave modport is the environment's view.
interface cache_axi_bridge_if;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic         ret_last;
  logic [31:0]  ret_data;
  logic         wr_req;
  logic [31:0]  wr_addr;
  logic [127:0] wr_data;
  logic         wr_rdy;

  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic         rlast;
  logic         rvalid;
  logic         rready;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic         awvalid;
  logic         awready;
  logic [3:0]   wid;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic         bvalid;
  logic         bready;

  modport master (
    input  rd_req, rd_type, rd_addr, wr_req, wr_addr, wr_data,
           arready, rdata, rlast, rvalid, awready, wready, bvalid,
    output rd_rdy, ret_valid, ret_last, ret_data, wr_rdy,
           arid, araddr, arlen, arsize, arvalid, rready,
           awid, awaddr, awvalid, wid, wdata, wstrb, wlast, wvalid, bready
  );

  modport slave (
    output rd_req, rd_type, rd_addr, wr_req, wr_addr, wr_data,
           arready, rdata, rlast, rvalid, awready, wready, bvalid,
    input  rd_rdy, ret_valid, ret_last, ret_data, wr_rdy,
           arid, araddr, arlen, arsize, arvalid, rready,
           awid, awaddr, awvalid, wid, wdata, wstrb, wlast, wvalid, bready
  );
endinterface

// File: rtl/cache_axi_bridge.sv
// Cache-to-AXI4 bridge: line refills and single-beat reads on AR/R, 4-beat line
// writebacks on AW/W/B, with reads to a line still being written back held off.
module cache_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic             clk,
  input  logic             resetn,
  cache_axi_bridge_if.master bus
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_DATA, W_RESP} wr_state_t;

  rd_state_t    rd_state;
  wr_state_t    wr_state;

  logic [31:0]  ar_addr_q;
  logic [7:0]   ar_len_q;
  logic [2:0]   ar_size_q;
  logic         ar_valid_q;
  logic         r_ready_q;

  logic [27:0]  wr_line_q;
  logic [127:0] wr_data_q;
  logic         aw_valid_q;
  logic         w_valid_q;
  logic         b_ready_q;
  logic [1:0]   beat_q;

  logic         wr_busy;
  logic         raw_hit;
  logic         rd_line;

  // A read of the line still owned by the write FSM must wait until its B returns.
  assign wr_busy = (wr_state != W_IDLE);
  assign raw_hit = wr_busy && (bus.rd_addr[31:4] == wr_line_q);
  assign rd_line = (bus.rd_type == 3'b100);

  assign bus.rd_rdy    = resetn && (rd_state == R_IDLE) && !raw_hit;
  assign bus.wr_rdy    = resetn && (wr_state == W_IDLE);

  assign bus.ret_valid = bus.rvalid && r_ready_q;
  assign bus.ret_data  = bus.rdata;
  assign bus.ret_last  = bus.rlast;

  assign bus.arid    = AXI_ID;
  assign bus.araddr  = ar_addr_q;
  assign bus.arlen   = ar_len_q;
  assign bus.arsize  = ar_size_q;
  assign bus.arvalid = ar_valid_q;
  assign bus.rready  = r_ready_q;

  assign bus.awid    = AXI_ID;
  assign bus.awaddr  = {wr_line_q, 4'b0000};
  assign bus.awvalid = aw_valid_q;
  assign bus.wid     = AXI_ID;
  assign bus.wdata   = wr_data_q[{beat_q, 5'd0} +: 32];
  assign bus.wstrb   = '1;
  assign bus.wlast   = w_valid_q && (beat_q == 2'd3);
  assign bus.wvalid  = w_valid_q;
  assign bus.bready  = b_ready_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_state   <= R_IDLE;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (bus.rd_req && bus.rd_rdy) begin
            ar_addr_q  <= rd_line ? {bus.rd_addr[31:4], 4'b0000} : bus.rd_addr;
            ar_len_q   <= rd_line ? 8'd3 : 8'd0;
            ar_size_q  <= (bus.rd_type == 3'b000) ? 3'd0 :
                          (bus.rd_type == 3'b001) ? 3'd1 : 3'd2;
            ar_valid_q <= 1'b1;
            rd_state   <= R_AR;
          end
        end
        R_AR: begin
          if (bus.arready) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            rd_state   <= R_DATA;
          end
        end
        R_DATA: begin
          if (bus.rvalid && bus.rlast) begin
            r_ready_q <= 1'b0;
            rd_state  <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_state   <= W_IDLE;
      wr_line_q  <= '0;
      wr_data_q  <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      beat_q     <= '0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (bus.wr_req && bus.wr_rdy) begin
            wr_line_q  <= bus.wr_addr[31:4];
            wr_data_q  <= bus.wr_data;
            aw_valid_q <= 1'b1;
            wr_state   <= W_REQ;
          end
        end
        W_REQ: begin
          if (bus.awready) begin
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b1;
            beat_q     <= '0;
            wr_state   <= W_DATA;
          end
        end
        W_DATA: begin
          if (bus.wready) begin
            beat_q <= beat_q + 2'd1;
            if (beat_q == 2'd3) begin
              w_valid_q <= 1'b0;
              b_ready_q <= 1'b1;
              wr_state  <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bus.bvalid) begin
            b_ready_q <= 1'b0;
            wr_state  <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

endmodule
